board_link_ctrl: RTL

- Controls the 11-bit parallel inter-board link: check_out drives the peer board, check_in receives from it.
- Shares the outgoing bus between 4 local requesters using round-robin arbitration.
- Frames each word with a toggle strobe, waits for the peer's toggle acknowledge, and delivers received frames to local logic.
- Sits inside top_vga between the game logic and the check_in/check_out pins. Full-duplex and symmetric: both boards run the same block.

---
 rtl/board_link_ctrl_if.sv | 26 ++
 rtl/board_link_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/board_link_ctrl_if.sv
// Local-side handshake bundle of board_link_ctrl.
//   tx_req     : per-channel send request, held until the matching tx_ack
//   tx_data    : 4 x 7-bit payloads, channel i in bits [7i+6:7i]
//   tx_ack     : one-cycle pulse when channel i's payload has been latched
//   rx_valid   : one-cycle pulse, a frame from the peer has arrived
//   rx_channel : channel of the received frame
//   rx_data    : payload of the received frame
// master = local game logic, slave = link controller.
interface board_link_ctrl_if;
  logic [3:0]  tx_req;
  logic [27:0] tx_data;
  logic [3:0]  tx_ack;
  logic        rx_valid;
  logic [1:0]  rx_channel;
  logic [6:0]  rx_data;

  modport master (
    output tx_req, tx_data,
    input  tx_ack, rx_valid, rx_channel, rx_data
  );

  modport slave (
    input  tx_req, tx_data,
    output tx_ack, rx_valid, rx_channel, rx_data
  );
endinterface

// File: rtl/board_link_ctrl.sv
// Inter-board link controller for the 11-bit parallel check_in/check_out bus.
// Four local requesters share the outgoing bus through round-robin arbitration;
// each word is framed by a toggle strobe and completed by the peer's toggle
// acknowledge. Frames from the peer are delivered on the rx_* handshake.
// Bus format (both directions): [10] tx toggle, [9] ack toggle,
// [8:7] channel, [6:0] payload.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   lnk        : local handshake bundle (slave side)
//   check_in   : raw bus from the peer, asynchronous
//   check_out  : registered bus to the peer
//   link_busy  : high while the TX FSM is not idle
//   link_err   : ack timeout flag, cleared when the ack finally arrives
module board_link_ctrl #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned SETUP_CYCLES = 3,
  parameter int unsigned INIT_CYCLES  = 8,
  parameter logic [15:0] TIMEOUT      = 16'd50000
) (
  input  logic               clk,
  input  logic               rst,
  board_link_ctrl_if.slave   lnk,
  input  logic [10:0]        check_in,
  output logic [10:0]        check_out,
  output logic               link_busy,
  output logic               link_err
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_WAIT_ACK
  } state_t;

  localparam logic [15:0] INIT_LAST  = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [10:0] sync1, s_in;
  logic        tx_tgl, ack_tgl, rx_seen;
  logic [8:0]  out_word;
  logic [1:0]  ptr;
  logic [15:0] cnt;

  logic        gnt_vld;
  logic [1:0]  gnt_idx, idx;
  logic [6:0]  gnt_data;
  logic        ld_frame, flip_tgl, ack_ok;

  // Every check_out bit is a flop output.
  assign check_out = {tx_tgl, ack_tgl, out_word};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      s_in  <= '0;
    end else begin
      sync1 <= check_in;
      s_in  <= sync1;
    end
  end

  // Round-robin: first requester at or after ptr, wrapping.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_vld && lnk.tx_req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == 2'(i)) gnt_data = lnk.tx_data[7*i +: 7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     if (cnt == INIT_LAST)    state_nxt = S_IDLE;
      S_IDLE:     if (gnt_vld)             state_nxt = S_SETUP;
      S_SETUP:    if (cnt == SETUP_LAST)   state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (s_in[9] == tx_tgl)   state_nxt = S_IDLE;
      default:                             state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    link_busy = (state != S_IDLE);
    ld_frame  = (state == S_IDLE) && gnt_vld;
    flip_tgl  = (state == S_SETUP) && (cnt == SETUP_LAST);
    ack_ok    = (state == S_WAIT_ACK) && (s_in[9] == tx_tgl);
  end

  // One counter serves INIT, SETUP and the WAIT_ACK timeout; it restarts on
  // every state change and saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (cnt != TIMEOUT)     cnt <= cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_tgl     <= 1'b0;
      out_word   <= '0;
      ptr        <= '0;
      lnk.tx_ack <= '0;
      link_err   <= 1'b0;
    end else begin
      lnk.tx_ack <= '0;
      // INIT adopts the peer's ack so that both sides start in agreement.
      if (state == S_INIT) tx_tgl <= s_in[9];
      else if (flip_tgl)   tx_tgl <= ~tx_tgl;
      if (ld_frame) begin
        out_word   <= {gnt_idx, gnt_data};
        lnk.tx_ack <= 4'b0001 << gnt_idx;
        ptr        <= gnt_idx + 2'd1;
      end
      if (ack_ok)
        link_err <= 1'b0;
      else if ((state == S_WAIT_ACK) && (cnt == TIMEOUT - 16'd1))
        link_err <= 1'b1;
    end
  end

  // Receiver runs independently of the TX FSM except during INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_seen        <= 1'b0;
      ack_tgl        <= 1'b0;
      lnk.rx_valid   <= 1'b0;
      lnk.rx_channel <= '0;
      lnk.rx_data    <= '0;
    end else if (state == S_INIT) begin
      rx_seen      <= s_in[10];
      ack_tgl      <= s_in[10];
      lnk.rx_valid <= 1'b0;
    end else begin
      lnk.rx_valid <= 1'b0;
      if (s_in[10] != rx_seen) begin
        rx_seen        <= s_in[10];
        ack_tgl        <= s_in[10];
        lnk.rx_channel <= s_in[8:7];
        lnk.rx_data    <= s_in[6:0];
        lnk.rx_valid   <= 1'b1;
      end
    end
  end

endmodule
